watch_multi_alarm_core: RTL and testbench

Parametrised next-generation timekeeping core for the digital watch. It contains a second prescaler and a 24 h hh:mm:ss counter. It adds a bank of N_ALARMS independently programmable alarms and a ring/snooze state machine with auto-timeout and a snooze limit. It sits below the watch top level, replacing the single-alarm clock path; mode decoding and display formatting stay outside.

---
 rtl/watch_pkg.sv | 21 ++
 rtl/watch_time_counter.sv | 72 +++++++
 rtl/watch_multi_alarm_core.sv | 180 ++++++++++++++++++
 tb/tb_watch_multi_alarm_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared types, limits and helpers for the watch timekeeping core
package watch_pkg;

    localparam int HH_W = 5;
    localparam int MM_W = 6;

    localparam logic [HH_W-1:0] MAX_HH = 5'd23;
    localparam logic [MM_W-1:0] MAX_MM = 6'd59;
    localparam logic [MM_W-1:0] MAX_SS = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } ring_state_t;

    function automatic logic hhmm_valid(input logic [HH_W-1:0] h, input logic [MM_W-1:0] m);
        return (h <= MAX_HH) && (m <= MAX_MM);
    endfunction

endpackage

// File: rtl/watch_time_counter.sv
// rtl/watch_time_counter.sv - second prescaler and 24 h hh:mm:ss counter with checked load
module watch_time_counter
    import watch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 32768
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [HH_W-1:0] load_hh,
    input  logic [MM_W-1:0] load_mm,
    output logic [HH_W-1:0] hh,
    output logic [MM_W-1:0] mm,
    output logic [MM_W-1:0] ss,
    output logic            sec_pulse,
    output logic            load_err,
    output logic            minute_rollover
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          load_ok;

    always_comb begin
        load_ok   = load_en && hhmm_valid(load_hh, load_mm);
        presc_nxt = (presc == PRESC_TOP) ? '0 : presc + 1'b1;
    end

    // sec_pulse is registered one edge ahead so it is high exactly while presc sits at the top
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc           <= '0;
            sec_pulse       <= 1'b0;
            hh              <= '0;
            mm              <= '0;
            ss              <= '0;
            load_err        <= 1'b0;
            minute_rollover <= 1'b0;
        end else begin
            load_err        <= load_en && !load_ok;
            minute_rollover <= 1'b0;
            if (load_ok) begin
                hh        <= load_hh;
                mm        <= load_mm;
                ss        <= '0;
                presc     <= '0;
                sec_pulse <= (PRESC_TOP == '0);
            end else begin
                presc     <= presc_nxt;
                sec_pulse <= (presc_nxt == PRESC_TOP);
                if (sec_pulse) begin
                    if (ss == MAX_SS) begin
                        ss              <= '0;
                        minute_rollover <= 1'b1;
                        if (mm == MAX_MM) begin
                            mm <= '0;
                            hh <= (hh == MAX_HH) ? '0 : hh + 1'b1;
                        end else begin
                            mm <= mm + 1'b1;
                        end
                    end else begin
                        ss <= ss + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/watch_multi_alarm_core.sv
// rtl/watch_multi_alarm_core.sv - timekeeping core with alarm bank and ring/snooze state machine
module watch_multi_alarm_core
    import watch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 32768,
    parameter int N_ALARMS      = 4,
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_MIN    = 5,
    parameter int MAX_SNOOZE    = 3,
    localparam int IDX_W        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [HH_W-1:0]  load_hh,
    input  logic [MM_W-1:0]  load_mm,
    input  logic             alm_we,
    input  logic [IDX_W-1:0] alm_idx,
    input  logic [HH_W-1:0]  alm_hh,
    input  logic [MM_W-1:0]  alm_mm,
    input  logic             alm_en,
    input  logic             snooze,
    input  logic             dismiss,
    output logic [HH_W-1:0]  hh,
    output logic [MM_W-1:0]  mm,
    output logic [MM_W-1:0]  ss,
    output logic             sec_pulse,
    output logic             load_err,
    output logic             alarm_sound,
    output logic [IDX_W-1:0] alarm_idx,
    output logic             snoozed
);

    localparam int IDX_SPAN   = 1 << IDX_W;
    localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int RW         = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int SW         = $clog2(SNOOZE_SEC + 1);
    localparam int CW         = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [IDX_SPAN-1:0] IDX_MASK     = IDX_SPAN'((32'd1 << N_ALARMS) - 32'd1);
    localparam logic [RW-1:0]       RING_LAST    = RW'(RING_SEC - 1);
    localparam logic [SW-1:0]       SNOOZE_LOAD  = SW'(SNOOZE_SEC);
    localparam logic [CW-1:0]       SNOOZE_LIMIT = CW'(MAX_SNOOZE);

    logic            tc_load_err;
    logic            alm_err;
    logic            minute_rollover;

    logic [HH_W-1:0] a_hh [IDX_SPAN];
    logic [MM_W-1:0] a_mm [IDX_SPAN];
    logic [IDX_SPAN-1:0] a_en;

    logic             alm_ok;
    logic             kill;
    logic             hit;
    logic [IDX_W-1:0] win;

    ring_state_t      state;
    logic [RW-1:0]    ring_cnt;
    logic [SW-1:0]    snz_left;
    logic [CW-1:0]    snooze_cnt;

    watch_time_counter #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_time (
        .clk            (clk),
        .rst            (rst),
        .load_en        (load_en),
        .load_hh        (load_hh),
        .load_mm        (load_mm),
        .hh             (hh),
        .mm             (mm),
        .ss             (ss),
        .sec_pulse      (sec_pulse),
        .load_err       (tc_load_err),
        .minute_rollover(minute_rollover)
    );

    assign load_err = tc_load_err | alm_err;

    // Scan from the top so the lowest matching channel is the one left in win
    always_comb begin
        alm_ok = alm_we && IDX_MASK[alm_idx] && hhmm_valid(alm_hh, alm_mm);
        kill   = alm_ok && (alm_idx == alarm_idx) && (state != IDLE);
        hit    = 1'b0;
        win    = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (a_en[i] && (a_hh[i] == hh) && (a_mm[i] == mm)) begin
                hit = 1'b1;
                win = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IDX_SPAN; i++) begin
                a_hh[i] <= '0;
                a_mm[i] <= '0;
            end
            a_en    <= '0;
            alm_err <= 1'b0;
        end else begin
            alm_err <= alm_we && !alm_ok;
            if (alm_ok) begin
                a_hh[alm_idx] <= alm_hh;
                a_mm[alm_idx] <= alm_mm;
                a_en[alm_idx] <= alm_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ring_cnt    <= '0;
            snz_left    <= '0;
            snooze_cnt  <= '0;
            alarm_sound <= 1'b0;
            alarm_idx   <= '0;
            snoozed     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (minute_rollover && hit) begin
                        state       <= RINGING;
                        alarm_idx   <= win;
                        ring_cnt    <= '0;
                        snooze_cnt  <= '0;
                        alarm_sound <= 1'b1;
                    end
                end
                RINGING: begin
                    if (dismiss || kill) begin
                        state       <= IDLE;
                        alarm_sound <= 1'b0;
                        alarm_idx   <= '0;
                    end else if (snooze && (snooze_cnt < SNOOZE_LIMIT)) begin
                        state       <= SNOOZED;
                        snooze_cnt  <= snooze_cnt + 1'b1;
                        snz_left    <= SNOOZE_LOAD;
                        alarm_sound <= 1'b0;
                        snoozed     <= 1'b1;
                    end else if (sec_pulse) begin
                        if (ring_cnt == RING_LAST) begin
                            state       <= IDLE;
                            alarm_sound <= 1'b0;
                            alarm_idx   <= '0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                SNOOZED: begin
                    if (dismiss || kill) begin
                        state     <= IDLE;
                        snoozed   <= 1'b0;
                        alarm_idx <= '0;
                    end else if (sec_pulse) begin
                        if (snz_left == SW'(1)) begin
                            state       <= RINGING;
                            ring_cnt    <= '0;
                            snoozed     <= 1'b0;
                            alarm_sound <= 1'b1;
                        end else begin
                            snz_left <= snz_left - 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    alarm_sound <= 1'b0;
                    alarm_idx   <= '0;
                    snoozed     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watch_multi_alarm_core.sv
// tb/tb_watch_multi_alarm_core.sv - randomized and directed checks against a behavioural watch model
module tb_watch_multi_alarm_core;

    localparam int TPS = 4;
    localparam int NA  = 4;
    localparam int RS  = 10;
    localparam int SM  = 1;
    localparam int MS  = 2;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [4:0]    load_hh = '0;
    logic [5:0]    load_mm = '0;
    logic          alm_we = 1'b0;
    logic [IW-1:0] alm_idx = '0;
    logic [4:0]    alm_hh = '0;
    logic [5:0]    alm_mm = '0;
    logic          alm_en = 1'b0;
    logic          snooze = 1'b0;
    logic          dismiss = 1'b0;
    logic [4:0]    hh;
    logic [5:0]    mm;
    logic [5:0]    ss;
    logic          sec_pulse;
    logic          load_err;
    logic          alarm_sound;
    logic [IW-1:0] alarm_idx;
    logic          snoozed;

    int n_checks = 0;
    int n_errors = 0;

    watch_multi_alarm_core #(
        .TICKS_PER_SEC(TPS),
        .N_ALARMS     (NA),
        .RING_SEC     (RS),
        .SNOOZE_MIN   (SM),
        .MAX_SNOOZE   (MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_hh    (load_hh),
        .load_mm    (load_mm),
        .alm_we     (alm_we),
        .alm_idx    (alm_idx),
        .alm_hh     (alm_hh),
        .alm_mm     (alm_mm),
        .alm_en     (alm_en),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .sec_pulse  (sec_pulse),
        .load_err   (load_err),
        .alarm_sound(alarm_sound),
        .alarm_idx  (alarm_idx),
        .snoozed    (snoozed)
    );

    always #5 clk = ~clk;

    // Model: time of day in seconds, alarm mode 0=idle 1=ringing 2=snoozed, seconds left counters
    int m_tod, m_phase, m_mode, m_active, m_ring_left, m_snz_left, m_used;
    bit m_roll, m_lerr;
    int m_ah [NA];
    int m_am [NA];
    bit m_aen [NA];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_phase = 0; m_mode = 0; m_active = 0;
        m_ring_left = 0; m_snz_left = 0; m_used = 0; m_roll = 0; m_lerr = 0;
        for (int i = 0; i < NA; i++) begin
            m_ah[i] = 0; m_am[i] = 0; m_aen[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit pulse, lok, aok, kill;
        int cur_h, cur_m, w;
        pulse = (m_phase == TPS - 1);
        lok   = load_en && int'(load_hh) <= 23 && int'(load_mm) <= 59;
        aok   = alm_we && int'(alm_idx) < NA && int'(alm_hh) <= 23 && int'(alm_mm) <= 59;
        cur_h = m_tod / 3600;
        cur_m = (m_tod / 60) % 60;
        kill  = aok && m_mode != 0 && int'(alm_idx) == m_active;
        if (m_mode == 0) begin
            if (m_roll) begin
                w = -1;
                for (int i = NA - 1; i >= 0; i--)
                    if (m_aen[i] && m_ah[i] == cur_h && m_am[i] == cur_m) w = i;
                if (w >= 0) begin
                    m_mode = 1; m_active = w; m_ring_left = RS; m_used = 0;
                end
            end
        end else if (dismiss || kill) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (snooze && m_used < MS) begin
                m_mode = 2; m_used++; m_snz_left = SM * 60;
            end else if (pulse) begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = 0;
            end
        end else if (pulse) begin
            m_snz_left--;
            if (m_snz_left == 0) begin
                m_mode = 1; m_ring_left = RS;
            end
        end
        if (aok) begin
            m_ah[alm_idx] = int'(alm_hh); m_am[alm_idx] = int'(alm_mm); m_aen[alm_idx] = alm_en;
        end
        m_lerr = (load_en && !lok) || (alm_we && !aok);
        m_roll = 0;
        if (lok) begin
            m_tod = int'(load_hh) * 3600 + int'(load_mm) * 60;
            m_phase = 0;
        end else if (pulse) begin
            m_phase = 0;
            m_tod = (m_tod + 1) % 86400;
            m_roll = (m_tod % 60 == 0);
        end else begin
            m_phase++;
        end
    endtask

    task automatic check_outputs();
        check_eq("hh", 32'(hh), m_tod / 3600);
        check_eq("mm", 32'(mm), (m_tod / 60) % 60);
        check_eq("ss", 32'(ss), m_tod % 60);
        check_eq("sec_pulse", 32'(sec_pulse), 32'(m_phase == TPS - 1));
        check_eq("load_err", 32'(load_err), 32'(m_lerr));
        check_eq("alarm_sound", 32'(alarm_sound), 32'(m_mode == 1));
        check_eq("snoozed", 32'(snoozed), 32'(m_mode == 2));
        check_eq("alarm_idx", 32'(alarm_idx), (m_mode != 0) ? m_active : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        load_en = 1'b0; alm_we = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input int h, input int m);
        load_en = 1'b1; load_hh = 5'(h); load_mm = 6'(m);
        step();
    endtask

    task automatic do_alarm(input int idx, input int h, input int m, input bit en);
        alm_we = 1'b1; alm_idx = IW'(idx); alm_hh = 5'(h); alm_mm = 6'(m); alm_en = en;
        step();
    endtask

    task automatic wait_sound(input logic lvl, input int budget, input string tag);
        int k;
        k = 0;
        while (alarm_sound !== lvl && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 32'(alarm_sound), 32'(lvl));
    endtask

    initial begin
        int dur, r, c;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Midnight rollover and per-second pulse
        do_load(23, 59);
        run(240);
        check_eq("midnight_hh", 32'(hh), 0);
        check_eq("midnight_mm", 32'(mm), 0);
        check_eq("midnight_ss", 32'(ss), 0);

        // Rejected writes
        do_load(24, 10);
        check_eq("bad_load_err", 32'(load_err), 1);
        do_alarm(2, 7, 60, 1'b1);
        check_eq("bad_alm_err", 32'(load_err), 1);
        step();
        check_eq("err_single_pulse", 32'(load_err), 0);

        // Two channels on the same minute; lowest wins, then auto-off
        do_alarm(1, 7, 0, 1'b1);
        do_alarm(3, 7, 0, 1'b1);
        do_load(6, 59);
        wait_sound(1'b1, 300, "ring_rise");
        check_eq("ring_idx", 32'(alarm_idx), 1);
        check_eq("ring_rise_ss", 32'(ss), 0);
        dur = 0;
        while (alarm_sound === 1'b1 && dur < 200) begin
            step();
            dur++;
        end
        check_eq("ring_duration", dur, RS * TPS - 1);

        // Snooze twice, third snooze ignored, then dismiss
        do_load(6, 59);
        wait_sound(1'b1, 300, "snz_rise");
        run(2);
        snooze = 1'b1; step();
        check_eq("snz1_state", 32'(snoozed), 1);
        wait_sound(1'b1, 300, "snz1_rering");
        snooze = 1'b1; step();
        check_eq("snz2_state", 32'(snoozed), 1);
        wait_sound(1'b1, 300, "snz2_rering");
        snooze = 1'b1; step();
        check_eq("snz3_ignored", 32'(alarm_sound), 1);
        dismiss = 1'b1; step();
        check_eq("dismiss_idx", 32'(alarm_idx), 0);

        // Snooze and dismiss together
        do_load(6, 59);
        wait_sound(1'b1, 300, "both_rise");
        snooze = 1'b1; dismiss = 1'b1; step();
        check_eq("both_idle", 32'(alarm_sound | snoozed), 0);

        // Disabling the active channel while snoozed
        do_load(6, 59);
        wait_sound(1'b1, 300, "kill_rise");
        snooze = 1'b1; step();
        do_alarm(1, 7, 0, 1'b0);
        check_eq("kill_idle", 32'(snoozed), 0);

        // Asynchronous reset mid-ring
        do_load(6, 59);
        wait_sound(1'b1, 300, "rst_rise");
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
        do_load(6, 59);
        run(250);
        check_eq("no_alarm_after_rst", 32'(alarm_sound), 0);

        // Randomized traffic
        for (int i = 0; i < NA; i++)
            do_alarm(i, $urandom_range(0, 23), $urandom_range(1, 59), 1'b1);
        for (int n = 0; n < 6000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 1) begin
                load_en = 1'b1; load_hh = 5'($urandom_range(0, 25)); load_mm = 6'($urandom_range(0, 62));
            end else if (r < 4) begin
                c = $urandom_range(0, NA - 1);
                load_en = 1'b1; load_hh = 5'(m_ah[c]); load_mm = 6'((m_am[c] + 59) % 60);
            end else if (r < 8) begin
                alm_we = 1'b1; alm_idx = IW'($urandom_range(0, NA - 1));
                alm_hh = 5'($urandom_range(0, 24)); alm_mm = 6'($urandom_range(1, 61));
                alm_en = ($urandom_range(0, 3) != 0);
            end else if (r < 30) begin
                snooze = 1'b1;
            end else if (r < 34) begin
                dismiss = 1'b1;
            end else if (r < 36) begin
                snooze = 1'b1; dismiss = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
